// File: rtl/pwm_pio_generator.sv
// PWM generator driven by Nios PIO words: double-buffered period/duty shadows,
// immediate kill (stop bit0) and graceful stop at period end (stop bit1).
module pwm_pio_generator #(
  parameter int WIDTH      = 32,
  parameter int MIN_PERIOD = 2,
  parameter int CNT_W      = 16
) (
  input  logic             clk_clk,
  input  logic             reset_reset,
  input  logic [WIDTH-1:0] period_export,
  input  logic [WIDTH-1:0] duty_export,
  input  logic [31:0]      stop_export,
  output logic             pwm_out,
  output logic             period_start,
  output logic             running,
  output logic             cfg_err,
  output logic [CNT_W-1:0] period_count
);

  localparam logic [WIDTH-1:0] MinPer   = WIDTH'(MIN_PERIOD);
  localparam logic [WIDTH-1:0] OneW     = WIDTH'(1);
  localparam logic [CNT_W-1:0] OneC     = CNT_W'(1);

  typedef enum logic [1:0] {Idle, Run, Drain} stateT;

  stateT            state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] perSh_q, perSh_d;
  logic [WIDTH-1:0] dutySh_q, dutySh_d;
  logic [CNT_W-1:0] periodCount_q, periodCount_d;
  logic             pwm_q, pwm_d;
  logic             start_q, start_d;
  logic             running_q, running_d;
  logic             cfgErr_q, cfgErr_d;

  logic killReq;
  logic drainReq;
  logic periodOk;
  logic lastClock;
  logic unusedStopBits;

  assign killReq        = stop_export[0];
  assign drainReq       = stop_export[1];
  assign periodOk       = period_export >= MinPer;
  assign lastClock      = cnt_q == (perSh_q - OneW);
  assign unusedStopBits = ^stop_export[31:2];

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      state_q       <= Idle;
      cnt_q         <= '0;
      perSh_q       <= '0;
      dutySh_q      <= '0;
      periodCount_q <= '0;
      pwm_q         <= 1'b0;
      start_q       <= 1'b0;
      running_q     <= 1'b0;
      cfgErr_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      perSh_q       <= perSh_d;
      dutySh_q      <= dutySh_d;
      periodCount_q <= periodCount_d;
      pwm_q         <= pwm_d;
      start_q       <= start_d;
      running_q     <= running_d;
      cfgErr_q      <= cfgErr_d;
    end
  end

  // Kill beats both the wrap and the graceful stop; shadows reload only on a RUN wrap.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    perSh_d       = perSh_q;
    dutySh_d      = dutySh_q;
    periodCount_d = periodCount_q;
    case (state_q)
      Idle: begin
        cnt_d = '0;
        if (!killReq && !drainReq && periodOk) begin
          state_d  = Run;
          perSh_d  = period_export;
          dutySh_d = duty_export;
        end
      end
      Run, Drain: begin
        if (killReq) begin
          state_d = Idle;
          cnt_d   = '0;
        end else if (lastClock) begin
          cnt_d         = '0;
          periodCount_d = periodCount_q + OneC;
          if (state_q == Drain) begin
            state_d = Idle;
          end else begin
            if (periodOk) begin
              perSh_d  = period_export;
              dutySh_d = duty_export;
            end
            if (drainReq) state_d = Drain;
          end
        end else begin
          cnt_d = cnt_q + OneW;
          if (state_q == Run && drainReq) state_d = Drain;
        end
      end
      default: begin
        state_d = Idle;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs are registered from the next-state values so they align with cnt.
  always_comb begin
    running_d = state_d != Idle;
    pwm_d     = running_d && (cnt_d < dutySh_d);
    start_d   = running_d && (cnt_d == '0);
    cfgErr_d  = (state_q == Idle) && (stop_export[1:0] == 2'b00) && !periodOk;
  end

  assign pwm_out      = pwm_q;
  assign period_start = start_q;
  assign running      = running_q;
  assign cfg_err      = cfgErr_q;
  assign period_count = periodCount_q;

endmodule
